// File: rtl/dataframe_readout_ctrl.sv
// Dataframe readout sequencer: pops 234-bit frames from a FWFT FIFO and
// serialises each one into 32-bit valid/ready beats. It also maintains a
// saturating frame counter and an optional frame-count limit.
module dataframe_readout_ctrl #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned FRAME_WIDTH        = 234,
    parameter int unsigned CNT_WIDTH          = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          RST,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic [CNT_WIDTH-1:0]          frame_limit_i,
    input  logic                          fifo_empty_i,
    input  logic [FRAME_WIDTH-1:0]        fifo_dout_i,
    output logic                          fifo_rd_en_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [CNT_WIDTH-1:0]          frame_count_o
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned N_WORDS  = (FRAME_WIDTH + DW - 1) / DW;
    localparam int unsigned PAD_W    = N_WORDS * DW;
    localparam int unsigned IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [FRAME_WIDTH-1:0] frame_q;

    logic                   limit_hit_c;
    logic                   start_c;
    logic                   frame_end_c;
    logic                   post_hit_c;
    logic                   chain_c;
    logic [IDX_W-1:0]       idx_inc_c;
    logic [CNT_WIDTH-1:0]   count_inc_c;
    logic [CNT_WIDTH-1:0]   count_post_c;

    // Beat k of a frame, with the top beat zero-padded above the frame width.
    function automatic logic [DW-1:0] beat_of(input logic [FRAME_WIDTH-1:0] f,
                                              input logic [IDX_W-1:0]       k);
        logic [PAD_W-1:0] p;
        p = PAD_W'(f) >> (DW * 32'(k));
        return p[DW-1:0];
    endfunction

    // Start/chain decisions and the FWFT pop strobe, which coincides with the capture.
    always_comb begin
        limit_hit_c  = (frame_limit_i != '0) && (frame_count_o >= frame_limit_i);
        start_c      = (state == IDLE) && enable_i && !fifo_empty_i && !limit_hit_c;
        frame_end_c  = (state == SEND) && m_tready && (idx == LAST_IDX);
        idx_inc_c    = idx + IDX_W'(1);
        count_inc_c  = (frame_count_o == '1) ? frame_count_o
                                             : frame_count_o + CNT_WIDTH'(1);
        // A clear landing on the frame end wins, so the limit test sees zero.
        count_post_c = clear_i ? '0 : count_inc_c;
        post_hit_c   = (frame_limit_i != '0) && (count_post_c >= frame_limit_i);
        chain_c      = frame_end_c && !post_hit_c && enable_i && !fifo_empty_i;
        fifo_rd_en_o = !RST && (start_c || chain_c);
    end

    // Frame counter: clear has priority over a completing frame.
    always_ff @(posedge S_AXI_ACLK) begin
        if (RST) begin
            frame_count_o <= '0;
        end else if (clear_i) begin
            frame_count_o <= '0;
        end else if (frame_end_c) begin
            frame_count_o <= count_inc_c;
        end
    end

    // Readout state machine with registered stream and status outputs.
    always_ff @(posedge S_AXI_ACLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            frame_q  <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        frame_q  <= fifo_dout_i;
                        idx      <= '0;
                        m_tdata  <= beat_of(fifo_dout_i, '0);
                        m_tvalid <= 1'b1;
                        m_tlast  <= (LAST_IDX == '0);
                        busy_o   <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (m_tready) begin
                        if (idx != LAST_IDX) begin
                            idx     <= idx_inc_c;
                            m_tdata <= beat_of(frame_q, idx_inc_c);
                            m_tlast <= (idx_inc_c == LAST_IDX);
                        end else if (post_hit_c) begin
                            m_tdata  <= '0;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else if (chain_c) begin
                            frame_q <= fifo_dout_i;
                            idx     <= '0;
                            m_tdata <= beat_of(fifo_dout_i, '0);
                            m_tlast <= (LAST_IDX == '0);
                        end else begin
                            m_tdata  <= '0;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            busy_o   <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (clear_i || !limit_hit_c) begin
                        done_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dataframe_readout_ctrl.sv
// Directed/randomised bench for dataframe_readout_ctrl with a queue-based
// FIFO model and a beat scoreboard built from the frame layout.
module tb_dataframe_readout_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = 15;

    logic             S_AXI_ACLK;
    logic             RST;
    logic             enable_i;
    logic             clear_i;
    logic [CW-1:0]    frame_limit_i;
    logic             fifo_empty_i;
    logic [233:0]     fifo_dout_i;
    logic             fifo_rd_en_o;
    logic [31:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             busy_o;
    logic             done_o;
    logic [CW-1:0]    frame_count_o;

    dataframe_readout_ctrl #(
        .C_S_AXI_DATA_WIDTH(32),
        .FRAME_WIDTH(234),
        .CNT_WIDTH(CW)
    ) dut (
        .S_AXI_ACLK(S_AXI_ACLK),
        .RST(RST),
        .enable_i(enable_i),
        .clear_i(clear_i),
        .frame_limit_i(frame_limit_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_dout_i(fifo_dout_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .busy_o(busy_o),
        .done_o(done_o),
        .frame_count_o(frame_count_o)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    int unsigned tests;
    int unsigned failed;
    int unsigned pops;
    int unsigned hs_total;
    int unsigned hs_in_frame;
    int unsigned mcnt;
    logic [233:0] fq[$];
    logic [32:0]  expq[$];
    logic         prev_stall;
    logic [31:0]  prev_data;
    logic         prev_last;
    logic [31:0]  last_tlast_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [233:0] rand_frame();
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom();
        return p[233:0];
    endfunction

    // Expected beats of one frame: 32-bit slices of the zero-padded frame.
    task automatic push_expected(input logic [233:0] f);
        logic [255:0] p;
        p = {22'b0, f};
        for (int k = 0; k < 8; k++) expq.push_back({(k == 7) ? 1'b1 : 1'b0, p[k*32 +: 32]});
    endtask

    // One clock cycle: present FIFO head, score the pre-edge handshake, update model.
    task automatic cyc();
        logic rd;
        logic hs;
        logic tl;
        logic [32:0] e;
        fifo_empty_i = (fq.size() == 0);
        fifo_dout_i  = (fq.size() == 0) ? '0 : fq[0];
        #1;
        rd = fifo_rd_en_o;
        hs = m_tvalid && m_tready;
        tl = 1'b0;
        chk("rd_while_empty", 256'(rd && fifo_empty_i), 256'(0));
        if (RST) chk("rd_in_reset", 256'(rd), 256'(0));
        if (prev_stall) begin
            chk("stall_valid", 256'(m_tvalid), 256'(1));
            chk("stall_data", 256'(m_tdata), 256'(prev_data));
            chk("stall_last", 256'(m_tlast), 256'(prev_last));
        end
        if (hs && !RST) begin
            if (expq.size() == 0) begin
                chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
                e = expq.pop_front();
                chk("beat_data", 256'(m_tdata), 256'(e[31:0]));
                chk("beat_last", 256'(m_tlast), 256'(e[32]));
            end
            tl = m_tlast;
            if (m_tlast) last_tlast_data = m_tdata;
            hs_total++;
            hs_in_frame = m_tlast ? 0 : hs_in_frame + 1;
        end
        if (rd && !RST && fq.size() != 0) begin
            push_expected(fq[0]);
            pops++;
        end
        prev_stall = m_tvalid && !m_tready && !RST;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        @(posedge S_AXI_ACLK);
        if (rd && fq.size() != 0) void'(fq.pop_front());
        if (RST) begin
            mcnt = 0;
            expq.delete();
            hs_in_frame = 0;
            prev_stall = 1'b0;
        end else if (clear_i) begin
            mcnt = 0;
        end else if (tl && mcnt < CMAX) begin
            mcnt++;
        end
        #1;
        chk("frame_count", 256'(frame_count_o), 256'(mcnt));
        chk("tvalid_outstanding", 256'(m_tvalid), 256'(expq.size() != 0));
        chk("busy_outstanding", 256'(busy_o), 256'(expq.size() != 0));
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
    endtask

    initial begin
        logic [233:0] f;
        logic [233:0] t5_frame;
        int unsigned pops0;
        int unsigned hs0;
        int unsigned first_v;
        int unsigned last_v;
        int unsigned n_v;
        tests = 0; failed = 0; pops = 0; hs_total = 0; hs_in_frame = 0; mcnt = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; last_tlast_data = '0;
        RST = 1'b1; enable_i = 1'b0; clear_i = 1'b0; frame_limit_i = '0;
        m_tready = 1'b0; fifo_empty_i = 1'b1; fifo_dout_i = '0;

        // Reset state
        repeat (3) cyc();
        chk("rst_tdata", 256'(m_tdata), 256'(0));
        chk("rst_tlast", 256'(m_tlast), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        chk("rst_rd_en", 256'(fifo_rd_en_o), 256'(0));
        RST = 1'b0;
        cyc();

        // Single known frame
        f = '0;
        for (int k = 0; k < 7; k++) f[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
        f[233:224] = 10'h3FF;
        fq.push_back(f);
        m_tready = 1'b1;
        enable_i = 1'b1;
        pops0 = pops;
        repeat (12) cyc();
        chk("t1_pops", 256'(pops - pops0), 256'(1));
        chk("t1_beat7", 256'(last_tlast_data), 256'(32'h0000_03FF));
        chk("t1_count", 256'(frame_count_o), 256'(1));
        chk("t1_idle", 256'(m_tvalid), 256'(0));

        // Four queued frames, back to back with no bubbles
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(rand_frame());
        cyc();
        enable_i = 1'b1;
        pops0 = pops; first_v = 0; last_v = 0; n_v = 0;
        for (int c = 1; c <= 45; c++) begin
            cyc();
            if (m_tvalid) begin
                if (n_v == 0) first_v = 32'(c);
                last_v = 32'(c);
                n_v++;
            end
        end
        chk("t2_valid_beats", 256'(n_v), 256'(32));
        chk("t2_no_gaps", 256'(last_v - first_v + 1), 256'(32));
        chk("t2_pops", 256'(pops - pops0), 256'(4));
        chk("t2_count", 256'(frame_count_o), 256'(5));

        // Frame limit of 3 with 5 queued, then clear and resume
        enable_i = 1'b0;
        frame_limit_i = CW'(3);
        pulse_clear();
        for (int i = 0; i < 5; i++) fq.push_back(rand_frame());
        enable_i = 1'b1;
        pops0 = pops;
        repeat (40) cyc();
        chk("t3_done", 256'(done_o), 256'(1));
        chk("t3_count", 256'(frame_count_o), 256'(3));
        chk("t3_fifo_left", 256'(fq.size()), 256'(2));
        chk("t3_pops", 256'(pops - pops0), 256'(3));
        fq.push_back(rand_frame());
        pops0 = pops;
        pulse_clear();
        repeat (40) cyc();
        chk("t3b_pops", 256'(pops - pops0), 256'(3));
        chk("t3b_done", 256'(done_o), 256'(1));
        chk("t3b_fifo_left", 256'(fq.size()), 256'(0));
        frame_limit_i = '0;
        repeat (2) cyc();
        chk("t3_release", 256'(done_o), 256'(0));

        // Random backpressure
        enable_i = 1'b0;
        pulse_clear();
        for (int i = 0; i < 6; i++) fq.push_back(rand_frame());
        enable_i = 1'b1;
        for (int c = 0; c < 400; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            cyc();
            if (fq.size() == 0 && expq.size() == 0) break;
        end
        m_tready = 1'b1;
        cyc();
        chk("t4_drained", 256'(fq.size() + expq.size()), 256'(0));
        chk("t4_count", 256'(frame_count_o), 256'(6));

        // enable dropped mid-frame, clear on the tlast handshake
        enable_i = 1'b0;
        pulse_clear();
        for (int i = 0; i < 3; i++) fq.push_back(rand_frame());
        t5_frame = fq[0];
        enable_i = 1'b1;
        pops0 = pops;
        hs0 = hs_total;
        for (int c = 0; c < 30; c++) begin
            if (hs_in_frame == 4) enable_i = 1'b0;
            clear_i = m_tvalid && m_tlast;
            cyc();
        end
        clear_i = 1'b0;
        chk("t5_pops", 256'(pops - pops0), 256'(1));
        chk("t5_beats", 256'(hs_total - hs0), 256'(8));
        chk("t5_fifo_left", 256'(fq.size()), 256'(2));
        chk("t5_beat7", 256'(last_tlast_data), 256'({22'b0, t5_frame[233:224]}));
        chk("t5_count_cleared", 256'(frame_count_o), 256'(0));

        // Counter saturation with an all-ones 4-bit counter
        for (int i = 0; i < 16; i++) fq.push_back(rand_frame());
        enable_i = 1'b1;
        repeat (18 * 8 + 10) cyc();
        chk("t6_saturated", 256'(frame_count_o), 256'(CMAX));
        chk("t6_drained", 256'(fq.size()), 256'(0));

        // Reset in the middle of a frame
        enable_i = 1'b0;
        fq.push_back(rand_frame());
        fq.push_back(rand_frame());
        enable_i = 1'b1;
        pops0 = pops;
        for (int c = 0; c < 30; c++) begin
            if (hs_in_frame == 5) break;
            cyc();
        end
        RST = 1'b1;
        enable_i = 1'b0;
        cyc();
        chk("t7_tvalid", 256'(m_tvalid), 256'(0));
        chk("t7_tlast", 256'(m_tlast), 256'(0));
        chk("t7_tdata", 256'(m_tdata), 256'(0));
        chk("t7_busy", 256'(busy_o), 256'(0));
        chk("t7_done", 256'(done_o), 256'(0));
        chk("t7_count", 256'(frame_count_o), 256'(0));
        chk("t7_rd_en", 256'(fifo_rd_en_o), 256'(0));
        RST = 1'b0;
        repeat (10) cyc();
        chk("t7_pops", 256'(pops - pops0), 256'(1));
        chk("t7_fifo_left", 256'(fq.size()), 256'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
